// File: rtl/uart_port.sv
// rtl/uart_port.sv - 8N1 UART transmitter/receiver driving the j1 UART strobe interface
module uart_port #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       uart0_wr,
    input  logic [7:0] uart_w,
    output logic       uart0_busy,
    input  logic       uart0_rd,
    output logic       uart0_valid,
    output logic [7:0] uart0_data,
    input  logic       uart0_rx,
    output logic       uart0_tx,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [15:0] BIT_CNT  = 16'(CLKS_PER_BIT);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // Counters load a full period and roll over on the cycle they read 1.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (uart0_wr) begin
                    tx_state_d = ST_START;
                    tx_shift_d = uart_w;
                    tx_cnt_d   = BIT_CNT;
                    tx_bit_d   = '0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = BIT_CNT;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_cnt_d   = BIT_CNT;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == 16'd1) begin
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        uart0_tx   = 1'b1;
        uart0_busy = 1'b1;
        case (tx_state_q)
            ST_IDLE:  uart0_busy = 1'b0;
            ST_START: uart0_tx   = 1'b0;
            ST_DATA:  uart0_tx   = tx_shift_q[0];
            default:  uart0_tx   = 1'b1;
        endcase
    end

    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart0_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state_q  <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // A completing byte takes priority over a read in the same cycle.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        data_d      = data_q;
        valid_d     = valid_q && !uart0_rd;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = HALF_CNT;
                end
            end
            ST_START: begin
                if (rx_cnt_q == 16'd1) begin
                    if (rx_sync_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_cnt_d   = BIT_CNT;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_CNT;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == 16'd1) begin
                    rx_state_d = ST_IDLE;
                    if (rx_sync_q) begin
                        data_d    = rx_shift_q;
                        valid_d   = 1'b1;
                        overrun_d = valid_q && !uart0_rd;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    assign uart0_valid  = valid_q;
    assign uart0_data   = data_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_port.sv
// tb/tb_uart_port.sv - directed self-checking bench for uart_port at 16 clocks per bit
module tb_uart_port;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       uart0_wr = 1'b0;
    logic [7:0] uart_w = 8'h00;
    logic       uart0_rd = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       uart0_busy, uart0_valid, uart0_tx, uart0_rx;
    logic       rx_frame_err, rx_overrun;
    logic [7:0] uart0_data;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_valid_at, rx_err_cnt, rx_ovr_cnt;

    assign uart0_rx = loop_en ? uart0_tx : rx_drv;

    uart_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .resetq       (resetq),
        .uart0_wr     (uart0_wr),
        .uart_w       (uart_w),
        .uart0_busy   (uart0_busy),
        .uart0_rd     (uart0_rd),
        .uart0_valid  (uart0_valid),
        .uart0_data   (uart0_data),
        .uart0_rx     (uart0_rx),
        .uart0_tx     (uart0_tx),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one transmit frame starting the cycle after the accepting edge; counts off-waveform cycles.
    task automatic tx_expect(input logic [7:0] b, input int drop_at, output int bad);
        logic exp_tx;
        bad = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i < CPB) exp_tx = 1'b0;
            else if (i < 9 * CPB) exp_tx = b[3'((i - CPB) / CPB)];
            else exp_tx = 1'b1;
            if (uart0_tx !== exp_tx || uart0_busy !== 1'b1) bad++;
            uart0_wr = (i == drop_at);
            if (i == drop_at) uart_w = 8'h3C;
            step();
        end
        uart0_wr = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit, input int rd_at);
        rx_valid_at = -1;
        rx_err_cnt  = 0;
        rx_ovr_cnt  = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i < CPB) rx_drv = 1'b0;
            else if (i < 9 * CPB) rx_drv = b[3'((i - CPB) / CPB)];
            else rx_drv = stop_bit;
            uart0_rd = (i == rd_at);
            step();
            if (rx_valid_at < 0 && uart0_valid === 1'b1) rx_valid_at = i + 1;
            if (rx_frame_err === 1'b1) rx_err_cnt++;
            if (rx_overrun === 1'b1) rx_ovr_cnt++;
        end
        uart0_rd = 1'b0;
        rx_drv   = 1'b1;
    endtask

    task automatic test_reset();
        resetq = 1'b0;
        step();
        step();
        n_checks++; if (uart0_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart0_tx); end
        n_checks++; if (uart0_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", uart0_busy); end
        n_checks++; if (uart0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", uart0_valid); end
        n_checks++; if (uart0_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", uart0_data); end
        n_checks++; if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", rx_frame_err, rx_overrun); end
        resetq = 1'b1;
        step();
    endtask

    task automatic test_tx_frame();
        int bad;
        uart_w = 8'hA5;
        uart0_wr = 1'b1;
        step();
        uart0_wr = 1'b0;
        tx_expect(8'hA5, -1, bad);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tx_a5_wave: got %0d bad cycles want 0", bad); end
        n_checks++; if (uart0_busy !== 1'b0 || uart0_tx !== 1'b1) begin n_fail++; $display("FAIL tx_a5_end: got busy=%b tx=%b want busy=0 tx=1", uart0_busy, uart0_tx); end
    endtask

    task automatic test_tx_busy_drop();
        int bad;
        uart_w = 8'hA5;
        uart0_wr = 1'b1;
        step();
        uart0_wr = 1'b0;
        tx_expect(8'hA5, 40, bad);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tx_drop_wave: got %0d bad cycles want 0", bad); end
        n_checks++; if (uart0_busy !== 1'b0) begin n_fail++; $display("FAIL tx_drop_end_busy: got %b want 0", uart0_busy); end
        uart_w = 8'h3C;
        uart0_wr = 1'b1;
        step();
        uart0_wr = 1'b0;
        tx_expect(8'h3C, -1, bad);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tx_b2b_wave: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_rx_basic();
        rx_send(8'h5A, 1'b1, -1);
        n_checks++; if (rx_valid_at < 145 || rx_valid_at > 155) begin n_fail++; $display("FAIL rx_latency: got %0d want 145..155", rx_valid_at); end
        n_checks++; if (uart0_data !== 8'h5A) begin n_fail++; $display("FAIL rx_data: got %h want 5a", uart0_data); end
        n_checks++; if (rx_err_cnt !== 0 || rx_ovr_cnt !== 0) begin n_fail++; $display("FAIL rx_flags: got err=%0d ovr=%0d want 0 0", rx_err_cnt, rx_ovr_cnt); end
        uart0_rd = 1'b1;
        step();
        uart0_rd = 1'b0;
        n_checks++; if (uart0_valid !== 1'b0) begin n_fail++; $display("FAIL rd_clear: got %b want 0", uart0_valid); end
        n_checks++; if (uart0_data !== 8'h5A) begin n_fail++; $display("FAIL rd_data_keep: got %h want 5a", uart0_data); end
        uart0_rd = 1'b1;
        step();
        uart0_rd = 1'b0;
        n_checks++; if (uart0_valid !== 1'b0 || uart0_data !== 8'h5A) begin n_fail++; $display("FAIL rd_empty: got valid=%b data=%h want 0 5a", uart0_valid, uart0_data); end
    endtask

    task automatic test_rx_overrun();
        rx_send(8'h11, 1'b1, -1);
        n_checks++; if (rx_ovr_cnt !== 0 || uart0_data !== 8'h11) begin n_fail++; $display("FAIL ovr_first: got ovr=%0d data=%h want 0 11", rx_ovr_cnt, uart0_data); end
        rx_send(8'h22, 1'b1, -1);
        n_checks++; if (rx_ovr_cnt !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d want 1", rx_ovr_cnt); end
        n_checks++; if (uart0_data !== 8'h22 || uart0_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_data: got data=%h valid=%b want 22 1", uart0_data, uart0_valid); end
        rx_send(8'h11, 1'b1, -1);
        n_checks++; if (rx_ovr_cnt !== 1 || uart0_data !== 8'h11) begin n_fail++; $display("FAIL ovr_again: got ovr=%0d data=%h want 1 11", rx_ovr_cnt, uart0_data); end
        rx_send(8'h22, 1'b1, 10 * CPB - 6);
        n_checks++; if (rx_ovr_cnt !== 0) begin n_fail++; $display("FAIL rd_same_cycle_ovr: got %0d want 0", rx_ovr_cnt); end
        n_checks++; if (uart0_valid !== 1'b1 || uart0_data !== 8'h22) begin n_fail++; $display("FAIL rd_same_cycle_data: got valid=%b data=%h want 1 22", uart0_valid, uart0_data); end
        uart0_rd = 1'b1;
        step();
        uart0_rd = 1'b0;
    endtask

    task automatic test_rx_false_start();
        int errs = 0;
        int seen_valid = 0;
        rx_drv = 1'b0;
        repeat (4) step();
        rx_drv = 1'b1;
        repeat (40) begin
            step();
            if (rx_frame_err === 1'b1) errs++;
            if (uart0_valid === 1'b1) seen_valid++;
        end
        n_checks++; if (errs !== 0 || seen_valid !== 0) begin n_fail++; $display("FAIL false_start: got err=%0d valid_cycles=%0d want 0 0", errs, seen_valid); end
    endtask

    task automatic test_rx_frame_err();
        int errs;
        rx_send(8'h77, 1'b0, -1);
        errs = rx_err_cnt;
        repeat (30) begin
            step();
            if (rx_frame_err === 1'b1) errs++;
        end
        n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d want 1", errs); end
        n_checks++; if (uart0_valid !== 1'b0 || uart0_data !== 8'h22) begin n_fail++; $display("FAIL frame_err_hold: got valid=%b data=%h want 0 22", uart0_valid, uart0_data); end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        int t;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h81;
        loop_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            uart_w = bytes[k];
            uart0_wr = 1'b1;
            step();
            uart0_wr = 1'b0;
            t = 0;
            while (uart0_valid !== 1'b1 && t < 400) begin step(); t++; end
            n_checks++; if (t >= 400) begin n_fail++; $display("FAIL loop_timeout_%0d: got no valid in %0d cycles want valid", k, t); end
            n_checks++; if (uart0_data !== bytes[k]) begin n_fail++; $display("FAIL loop_data_%0d: got %h want %h", k, uart0_data, bytes[k]); end
            if (k < 2) begin
                uart0_rd = 1'b1;
                step();
                uart0_rd = 1'b0;
            end
            t = 0;
            while (uart0_busy !== 1'b0 && t < 400) begin step(); t++; end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        n_checks++; if (uart0_valid !== 1'b1 || uart0_data !== 8'h81) begin n_fail++; $display("FAIL pre_reset_hold: got valid=%b data=%h want 1 81", uart0_valid, uart0_data); end
        uart_w = 8'h96;
        uart0_wr = 1'b1;
        step();
        uart0_wr = 1'b0;
        repeat (20) step();
        n_checks++; if (uart0_tx !== 1'b0 || uart0_busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_tx: got tx=%b busy=%b want 0 1", uart0_tx, uart0_busy); end
        #2 resetq = 1'b0;
        #1;
        n_checks++; if (uart0_tx !== 1'b1 || uart0_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_tx: got tx=%b busy=%b want 1 0", uart0_tx, uart0_busy); end
        n_checks++; if (uart0_valid !== 1'b0 || uart0_data !== 8'h00) begin n_fail++; $display("FAIL async_reset_rx: got valid=%b data=%h want 0 00", uart0_valid, uart0_data); end
        step();
        step();
        resetq = 1'b1;
        step();
        uart_w = 8'h3C;
        uart0_wr = 1'b1;
        step();
        uart0_wr = 1'b0;
        tx_expect(8'h3C, -1, bad);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL post_reset_wave: got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_tx_busy_drop();
        test_rx_basic();
        test_rx_overrun();
        test_rx_false_start();
        test_rx_frame_err();
        test_loopback();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
